// File: rtl/aes128_round_sequencer.sv
// Iterative AES-128 encryption: one full-round datapath and one last-round datapath,
// stepped once per clock over ten rounds, with valid/ready handshakes on both sides.
module aes128_round_sequencer (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy,
  output logic [3:0]   round
);

  localparam int unsigned BLK_W    = 128;
  localparam int unsigned RND_W    = 4;
  localparam logic [RND_W-1:0] NR  = RND_W'(10);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [BLK_W-1:0]   st;
  logic [BLK_W-1:0]   rk;
  logic [RND_W-1:0]   rnd;

  logic [BLK_W-1:0]   rk_gen;
  logic [BLK_W-1:0]   sr_out;
  logic [BLK_W-1:0]   round_out;
  logic [BLK_W-1:0]   last_out;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] pw;
    inv = 8'h01;
    pw  = x;
    for (int i = 1; i < 8; i++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [RND_W-1:0] rc);
    case (rc)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [BLK_W-1:0] key_gen(input logic [RND_W-1:0] rc,
                                                input logic [BLK_W-1:0] k);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^
         {rcon(rc), 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [BLK_W-1:0] sub_bytes(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
  function automatic logic [BLK_W-1:0] shift_rows(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [BLK_W-1:0] mix_columns(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  // Round datapath; SubBytes/ShiftRows and key generation are shared by both round flavours.
  always_comb begin
    rk_gen    = key_gen(rnd, rk);
    sr_out    = shift_rows(sub_bytes(st));
    round_out = mix_columns(sr_out) ^ rk_gen;
    last_out  = sr_out ^ rk_gen;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      st         <= '0;
      rk         <= '0;
      rnd        <= '0;
      ciphertext <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            st       <= plaintext ^ key;
            rk       <= key;
            rnd      <= RND_W'(1);
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (rnd == NR) begin
            ciphertext <= last_out;
            rnd        <= '0;
            state      <= DONE;
            out_valid  <= 1'b1;
          end else begin
            st  <= round_out;
            rk  <= rk_gen;
            rnd <= rnd + RND_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          rnd       <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign round = rnd;

endmodule

// File: tb/tb_aes128_round_sequencer.sv
// Bench for aes128_round_sequencer: FIPS-197 vectors, random vectors against a
// table-driven AES model, backpressure, resets mid-block and in DONE, back-to-back blocks.
module tb_aes128_round_sequencer;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;
  logic [3:0]   round;

  int checks;
  int errors;
  int cyc;

  localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RK10_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_C   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] RK10_C  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  aes128_round_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy),
    .round      (round)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  logic [7:0]   sbox_t [0:255];
  logic [127:0] mrk    [0:10];

  function automatic logic [7:0] m_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box built by walking generator 3 and its inverse together.
  task automatic build_sbox();
    logic [7:0] p, q, t, x;
    p = 8'h01;
    q = 8'h01;
    for (int n = 0; n < 255; n++) begin
      t = p;
      p = t ^ {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end
    sbox_t[0] = 8'h63;
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]};
        t[31:24] = t[31:24] ^ rc;
        rc = m_xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int n = 0; n < 11; n++) mrk[n] = {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endtask

  task automatic model_encrypt(input logic [127:0] pt, output logic [127:0] ct);
    logic [7:0] s [0:15];
    logic [7:0] tmp [0:15];
    logic [7:0] a0, a1, a2, a3;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ mrk[0][127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) tmp[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[row + 4*c] = tmp[row + 4*((c + row) % 4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = m_xt(a0) ^ (m_xt(a1) ^ a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ m_xt(a1) ^ (m_xt(a2) ^ a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ m_xt(a2) ^ (m_xt(a3) ^ a3);
          s[4*c+3] = (m_xt(a0) ^ a0) ^ a1 ^ a2 ^ m_xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ mrk[r][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
  endtask

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output logic ok);
    int n;
    n = 0;
    while (!in_ready && n < 60) begin
      tick();
      n++;
    end
    ok = in_ready;
  endtask

  task automatic wait_out(output logic ok);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    ok = out_valid;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, busy, round} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL reset_flags: got in_ready=%b out_valid=%b busy=%b round=%0d want 1 0 0 0",
               in_ready, out_valid, busy, round);
    end
    checks++;
    if (ciphertext !== 128'h0) begin
      errors++;
      $display("FAIL reset_ct: got %h want 0", ciphertext);
    end
  endtask

  // One block with out_ready high: latency, round sequence, key taps, result, return to IDLE.
  task automatic test_vector(input logic [127:0] pt, input logic [127:0] k,
                             input logic [127:0] exp_ct, input logic [127:0] exp_rk10,
                             input string name);
    logic ok;
    logic [127:0] exp_rk9;
    int n;
    model_expand(k);
    exp_rk9 = mrk[9];
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_idle: in_ready=%b want 1", name, in_ready);
    end
    out_ready = 1'b1;
    plaintext = pt;
    key       = k;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    plaintext = '0;
    key       = '0;
    n = 0;
    while (!out_valid && n < 30) begin
      checks++;
      if (round !== 4'(n + 1)) begin
        errors++;
        $display("FAIL %s_round: got %0d want %0d", name, round, n + 1);
      end
      if (round == 4'd10) begin
        checks++;
        if (dut.rk !== exp_rk9) begin
          errors++;
          $display("FAIL %s_rk9: got %h want %h", name, dut.rk, exp_rk9);
        end
        checks++;
        if (dut.rk_gen !== exp_rk10) begin
          errors++;
          $display("FAIL %s_rk10: got %h want %h", name, dut.rk_gen, exp_rk10);
        end
      end
      tick();
      n++;
    end
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges after accept want 10", name, n);
    end
    checks++;
    if (ciphertext !== exp_ct) begin
      errors++;
      $display("FAIL %s_ct: got %h want %h", name, ciphertext, exp_ct);
    end
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_flags: in_ready=%b busy=%b want 0 1", name, in_ready, busy);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_back_idle: in_ready=%b out_valid=%b want 1 0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_random();
    logic [127:0] pt, k, ct;
    for (int v = 0; v < 4; v++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      k  = {$urandom, $urandom, $urandom, $urandom};
      model_expand(k);
      model_encrypt(pt, ct);
      test_vector(pt, k, ct, mrk[10], $sformatf("rand%0d", v));
    end
  endtask

  task automatic test_backpressure();
    logic ok;
    int bad;
    wait_idle(ok);
    out_ready = 1'b0;
    plaintext = PT_B;
    key       = KEY_B;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    wait_out(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_out_valid: out_valid=%b want 1", out_valid);
    end
    plaintext = PT_C;
    key       = KEY_C;
    in_valid  = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || ciphertext !== CT_B)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d bad cycles, last ct=%h ov=%b ir=%b want ct=%h ov=1 ir=0",
               bad, ciphertext, out_valid, in_ready, CT_B);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || ciphertext !== CT_B) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b ct=%h want 1 0 %h",
               in_ready, out_valid, ciphertext, CT_B);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (round !== 4'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept_held: round=%0d busy=%b want 1 1", round, busy);
    end
    out_ready = 1'b1;
    wait_out(ok);
    checks++;
    if (ciphertext !== CT_C) begin
      errors++;
      $display("FAIL bp_second_ct: got %h want %h", ciphertext, CT_C);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic ok;
    int n;
    wait_idle(ok);
    out_ready = 1'b1;
    plaintext = PT_C;
    key       = KEY_C;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    n = 0;
    while (round != 4'd5 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (round !== 4'd5) begin
      errors++;
      $display("FAIL rmid_reach5: round=%0d want 5", round);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, busy, round} !== {1'b1, 1'b0, 1'b0, 4'd0} ||
        ciphertext !== 128'h0) begin
      errors++;
      $display("FAIL rmid_state: ir=%b ov=%b busy=%b round=%0d ct=%h want 1 0 0 0 0",
               in_ready, out_valid, busy, round, ciphertext);
    end
    test_vector(PT_B, KEY_B, CT_B, RK10_B, "rmid_fresh");
  endtask

  task automatic test_back_to_back();
    logic ok;
    logic [3:0] prev;
    logic [127:0] got [0:1];
    int acc, outs, t_acc [0:1];
    wait_idle(ok);
    out_ready = 1'b1;
    plaintext = PT_B;
    key       = KEY_B;
    in_valid  = 1'b1;
    acc = 0;
    outs = 0;
    prev = 4'd0;
    t_acc[0] = 0;
    t_acc[1] = 0;
    got[0] = '0;
    got[1] = '0;
    for (int n = 0; n < 60 && outs < 2; n++) begin
      tick();
      if (round != 4'd0) begin
        checks++;
        if (round !== ((prev == 4'd0) ? 4'd1 : prev + 4'd1)) begin
          errors++;
          $display("FAIL b2b_monotonic: round=%0d after %0d", round, prev);
        end
      end
      if (round == 4'd1 && prev != 4'd1 && acc < 2) begin
        t_acc[acc] = cyc;
        acc++;
        if (acc == 1) begin
          plaintext = PT_C;
          key       = KEY_C;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        got[outs] = ciphertext;
        outs++;
      end
      prev = round;
    end
    in_valid = 1'b0;
    checks++;
    if (acc != 2 || outs != 2) begin
      errors++;
      $display("FAIL b2b_counts: accepts=%0d results=%0d want 2 2", acc, outs);
    end
    checks++;
    if (t_acc[1] - t_acc[0] != 12) begin
      errors++;
      $display("FAIL b2b_interval: got %0d want 12", t_acc[1] - t_acc[0]);
    end
    checks++;
    if (got[0] !== CT_B) begin
      errors++;
      $display("FAIL b2b_ct0: got %h want %h", got[0], CT_B);
    end
    checks++;
    if (got[1] !== CT_C) begin
      errors++;
      $display("FAIL b2b_ct1: got %h want %h", got[1], CT_C);
    end
  endtask

  task automatic test_reset_done();
    logic ok;
    int seen;
    wait_idle(ok);
    out_ready = 1'b0;
    plaintext = PT_B;
    key       = KEY_B;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    wait_out(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rdone_reach: out_valid=%b want 1", out_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || ciphertext !== 128'h0) begin
      errors++;
      $display("FAIL rdone_drop: out_valid=%b in_ready=%b ct=%h want 0 1 0",
               out_valid, in_ready, ciphertext);
    end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rdone_represent: out_valid high %0d cycles want 0", seen);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    plaintext = '0;
    key       = '0;
    build_sbox();
    test_reset();
    test_vector(PT_B, KEY_B, CT_B, RK10_B, "fips_b");
    test_vector(PT_C, KEY_C, CT_C, RK10_C, "fips_c1");
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_reset_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes128_round_sequencer.md
# aes128_round_sequencer

Iterative AES-128 encryption controller that owns a single full-round datapath and a single last-round datapath and sequences them over ten rounds per block. It sits between the block-level host interface and the round hardware. It accepts one plaintext/key pair through a valid/ready handshake, runs the initial AddRoundKey, nine full rounds and the final round one per clock, and presents the ciphertext through a second valid/ready handshake.

## Interface
Parameters:
- none; Nr is fixed at 10 and the key width at 128.

Ports:
- clk  in  1  rising-edge clock for all state.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  plaintext/key pair offered.
- in_ready  out  1  block can accept a pair; high only in IDLE.
- plaintext  in  128  input block; byte 0 is in bits [127:120].
- key  in  128  cipher key, same byte order.
- out_valid  out  1  ciphertext valid; high only in DONE.
- out_ready  in  1  downstream accepts ciphertext.
- ciphertext  out  128  result register.
- busy  out  1  high in RUN or DONE.
- round  out  4  current round counter, 0 in IDLE; for debug.

## Operation
- FSM states are IDLE, RUN and DONE. Registers are the 128-bit state `st`, the 128-bit running key `rk`, and the 4-bit counter `rnd`.
- The datapath is combinational and built from the team's existing units:
  - RoundKeyGenerator, with rc = rnd and inkey = rk.
  - ByteSubstitution, then ShiftRows, then MixColumns, then XOR with the generated key. This is the full round.
  - roundlast, with rc = rnd, rin = st and keylastin = rk. This is SubBytes, then ShiftRows, then AddRoundKey, with no MixColumns.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: st <= plaintext ^ key, rk <= key, rnd <= 1, and the FSM moves to RUN.
  - plaintext and key are sampled only on this edge.
- RUN, with rnd in 1..9:
  - st <= full_round(st, RKG(rnd, rk)).
  - rk <= RKG(rnd, rk).
  - rnd <= rnd + 1.
- RUN, with rnd == 10:
  - ciphertext <= roundlast output.
  - rnd <= 0.
  - The FSM moves to DONE.
- DONE:
  - out_valid = 1 and ciphertext is held stable.
  - On out_ready, the FSM moves to IDLE.
  - Without out_ready, it stays in DONE indefinitely.
- in_valid is ignored outside IDLE. There is no queuing and no overwrite of a pending result.
- rnd never exceeds 10 and never wraps. The rc value seen by the key generator is always in 1..10 during RUN.
- ciphertext keeps its value after leaving DONE until the next result is written. Only reset clears it.

## Timing
- Reset (synchronous, rst high at a clk edge) sets:
  - state = IDLE.
  - st, rk, ciphertext = 0.
  - rnd = 0.
  - in_ready = 1.
  - out_valid = 0.
  - busy = 0.
- Reset asserted in RUN or DONE aborts the block. The pending result is discarded and out_valid drops the cycle after the reset edge.
- Latency: accept edge at cycle T, RUN during cycles T+1..T+10, out_valid first high in cycle T+11. This is 11 edges from accept to result.
- Minimum initiation interval is 12 cycles: accept, 10 rounds, 1 DONE cycle with out_ready already high, then back to IDLE. in_ready is high again in cycle T+12.
- in_ready and out_valid are registered-state decodes and are never high in the same cycle.
- A simultaneous in_valid in DONE is not accepted in that cycle. It is accepted in the following IDLE cycle if still held.
- The combinational path is at most one full round plus key generation per cycle.

## Test plan
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734, out_ready=1 -> ciphertext 3925841d02dc09fbdc118597196a0b32, with out_valid exactly 11 cycles after the accept edge and in_ready back high one cycle later.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a. While in RUN for round 10, rk equals the round-9 key and the generated key equals d014f9a8c9ee2589e13f0cc8b6630ca6 (App. B key) / 13111d7fe3944a17f307a78b4d2b30c5 (App. C.1 key).
- Backpressure: hold out_ready=0 for 20 cycles after completion -> out_valid stays 1, ciphertext is stable, in_ready stays 0, and a new in_valid with different data is ignored. Raising out_ready for 1 cycle -> IDLE, and the held in_valid is accepted the next cycle.
- Reset mid-operation: assert rst during round 5 -> the next cycle shows IDLE, round=0, busy=0, ciphertext=0. A fresh App. B vector then yields the correct result with no residue from the aborted block.
- Back-to-back: App. B then App. C.1, with in_valid held continuously and out_ready=1 -> both ciphertexts are correct, accepts are 12 cycles apart, and round counts 1..10 are monotonic for each block.
- Reset with out_valid high in DONE -> out_valid=0 the next cycle and the result is never re-presented.
